// File: rtl/cmd_sequencer_if.sv
// Handshake bundle between cmd_sequencer and its UART/datapath neighbours.
// The master modport is the sequencer side; slave is the UART/datapath side.
interface cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_ready;
  logic        max_req;
  logic [1:0]  max_ch;
  logic        max_valid;
  logic [15:0] max_value;
  logic        trig_arm;
  logic        trig_hit;
  logic        busy;
  logic [7:0]  overrun_cnt;

  modport master (
    input  rx_data, rx_data_ready, tx_ready, max_valid, max_value, trig_hit,
    output tx_data, tx_en, max_req, max_ch, trig_arm, busy, overrun_cnt
  );

  modport slave (
    output rx_data, rx_data_ready, tx_ready, max_valid, max_value, trig_hit,
    input  tx_data, tx_en, max_req, max_ch, trig_arm, busy, overrun_cnt
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Host command sequencer: decodes UART command bytes, runs a datapath max/trigger
// operation, then streams the response out. Optional build macro: CMD_CHECKSUM_EN.
module cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned TIMEOUT_W      = 32'd32
) (
  input logic             clk,
  input logic             reset,
  cmd_sequencer_if.master bus
);
  localparam logic [7:0] OP_MAX0  = 8'h41;
  localparam logic [7:0] OP_MAX1  = 8'h42;
  localparam logic [7:0] OP_TRIG  = 8'hD0;
  localparam logic [7:0] OP_PING  = 8'h00;
  localparam logic [7:0] RSP_ERR  = 8'hEE;
  localparam logic [7:0] RSP_HIT  = 8'hD1;
  localparam logic [7:0] RSP_TMO  = 8'hDE;
  localparam logic [7:0] RSP_PING = 8'hAA;
  localparam logic [TIMEOUT_W-1:0] TIMER_ZERO = {TIMEOUT_W{1'b0}};
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = TIMEOUT_W'(1'b1);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);

`ifdef CMD_CHECKSUM_EN
  localparam int unsigned BUF_DEPTH = 32'd4;
  localparam logic [2:0]  CHK_LEN   = 3'd1;

  function automatic logic [7:0] resp_xor(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    return a ^ b ^ c;
  endfunction
`else
  localparam int unsigned BUF_DEPTH = 32'd3;
  localparam logic [2:0]  CHK_LEN   = 3'd0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    MAX_WAIT  = 3'd2,
    TRIG_WAIT = 3'd3,
    TX_LOAD   = 3'd4,
    TX_HOLD   = 3'd5,
    TX_GAP    = 3'd6
  } state_t;

  state_t               state_r, state_s;
  logic [7:0]           opcode_r, opcode_s;
  logic [TIMEOUT_W-1:0] timer_r, timer_s;
  logic [1:0]           idx_r, idx_s;
  logic [2:0]           len_r, rsp_len_s;
  logic                 done_r, done_s;
  logic [7:0]           resp_buf_r [BUF_DEPTH];
  logic [7:0]           rsp_s [BUF_DEPTH];
  logic                 load_s;
  logic [7:0]           tx_data_r, tx_data_s;
  logic                 tx_en_r, tx_en_s;
  logic                 max_req_r, max_req_s;
  logic [1:0]           max_ch_r, max_ch_s;
  logic                 trig_arm_r, trig_arm_s;
  logic                 busy_r;
  logic [7:0]           overrun_r, overrun_s;

  // Next-state, response loading and next output values.
  always_comb begin
    state_s    = state_r;
    opcode_s   = opcode_r;
    timer_s    = timer_r;
    idx_s      = idx_r;
    done_s     = done_r;
    tx_data_s  = tx_data_r;
    tx_en_s    = tx_en_r;
    max_req_s  = 1'b0;
    max_ch_s   = max_ch_r;
    trig_arm_s = 1'b0;
    load_s     = 1'b0;
    rsp_len_s  = 3'd0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      rsp_s[i] = 8'h00;
    end
    case (state_r)
      IDLE: begin
        if (bus.rx_data_ready) begin
          opcode_s = bus.rx_data;
          state_s  = DECODE;
        end else begin
          state_s  = IDLE;
        end
      end
      DECODE: begin
        timer_s = TIMER_ZERO;
        idx_s   = 2'd0;
        done_s  = 1'b0;
        case (opcode_r)
          OP_MAX0: begin max_ch_s = 2'd0; state_s = MAX_WAIT; end
          OP_MAX1: begin max_ch_s = 2'd1; state_s = MAX_WAIT; end
          OP_TRIG: state_s = TRIG_WAIT;
          OP_PING: begin
            load_s = 1'b1; rsp_s[0] = RSP_PING; rsp_len_s = 3'd1; state_s = TX_LOAD;
          end
          default: begin
            load_s = 1'b1; rsp_s[0] = RSP_ERR; rsp_s[1] = opcode_r;
            rsp_len_s = 3'd2; state_s = TX_LOAD;
          end
        endcase
      end
      // The request strobe goes out on the first wait cycle; completion wins over timeout.
      MAX_WAIT: begin
        timer_s   = timer_r + TIMER_ONE;
        max_req_s = (timer_r == TIMER_ZERO);
        if (bus.max_valid) begin
          load_s = 1'b1; rsp_s[0] = opcode_r; rsp_s[1] = bus.max_value[15:8];
          rsp_s[2] = bus.max_value[7:0]; rsp_len_s = 3'd3; state_s = TX_LOAD;
        end else if (timer_r == TIMER_LAST) begin
          load_s = 1'b1; rsp_s[0] = RSP_ERR; rsp_s[1] = opcode_r;
          rsp_len_s = 3'd2; state_s = TX_LOAD;
        end else begin
          state_s = MAX_WAIT;
        end
      end
      TRIG_WAIT: begin
        timer_s    = timer_r + TIMER_ONE;
        trig_arm_s = (timer_r == TIMER_ZERO);
        if (bus.trig_hit) begin
          load_s = 1'b1; rsp_s[0] = RSP_HIT; rsp_len_s = 3'd1; state_s = TX_LOAD;
        end else if (timer_r == TIMER_LAST) begin
          load_s = 1'b1; rsp_s[0] = RSP_TMO; rsp_len_s = 3'd1; state_s = TX_LOAD;
        end else begin
          state_s = TRIG_WAIT;
        end
      end
      TX_LOAD: begin
        if (bus.tx_ready) begin
          tx_data_s = resp_buf_r[idx_r];
          tx_en_s   = 1'b1;
          state_s   = TX_HOLD;
        end else begin
          state_s   = TX_LOAD;
        end
      end
      // done_r marks the last byte so idx never has to count past the final slot.
      TX_HOLD: begin
        if (!bus.tx_ready) begin
          tx_en_s = 1'b0;
          if ({1'b0, idx_r} == (len_r - 3'd1)) begin
            done_s = 1'b1;
          end else begin
            idx_s  = idx_r + 2'd1;
          end
          state_s = TX_GAP;
        end else begin
          state_s = TX_HOLD;
        end
      end
      TX_GAP: begin
        if (done_r) begin
          state_s = IDLE;
        end else begin
          state_s = TX_LOAD;
        end
      end
      default: state_s = IDLE;
    endcase
`ifdef CMD_CHECKSUM_EN
    rsp_s[rsp_len_s[1:0]] = resp_xor(rsp_s[0], rsp_s[1], rsp_s[2]);
`endif
    if (bus.rx_data_ready && (state_r != IDLE) && (overrun_r != 8'hFF)) begin
      overrun_s = overrun_r + 8'd1;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State and output registers; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      opcode_r   <= 8'h00;
      timer_r    <= TIMER_ZERO;
      idx_r      <= 2'd0;
      len_r      <= 3'd0;
      done_r     <= 1'b0;
      tx_data_r  <= 8'h00;
      tx_en_r    <= 1'b0;
      max_req_r  <= 1'b0;
      max_ch_r   <= 2'd0;
      trig_arm_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 8'h00;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        resp_buf_r[i] <= 8'h00;
      end
    end else begin
      state_r    <= state_s;
      opcode_r   <= opcode_s;
      timer_r    <= timer_s;
      idx_r      <= idx_s;
      done_r     <= done_s;
      tx_data_r  <= tx_data_s;
      tx_en_r    <= tx_en_s;
      max_req_r  <= max_req_s;
      max_ch_r   <= max_ch_s;
      trig_arm_r <= trig_arm_s;
      busy_r     <= (state_s != IDLE);
      overrun_r  <= overrun_s;
      if (load_s) begin
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
          resp_buf_r[i] <= rsp_s[i];
        end
        len_r <= rsp_len_s + CHK_LEN;
      end else begin
        len_r <= len_r;
      end
    end
  end

  assign bus.tx_data     = tx_data_r;
  assign bus.tx_en       = tx_en_r;
  assign bus.max_req     = max_req_r;
  assign bus.max_ch      = max_ch_r;
  assign bus.trig_arm    = trig_arm_r;
  assign bus.busy        = busy_r;
  assign bus.overrun_cnt = overrun_r;
endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer with a small UART transmitter model.
module tb_cmd_sequencer;
  logic clk = 1'b0;
  logic rst;
  cmd_sequencer_if ifc();

  cmd_sequencer #(.TIMEOUT_CYCLES(32'd1000), .TIMEOUT_W(32'd32)) dut (
    .clk(clk), .reset(rst), .bus(ifc.master)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;
  int         hs_cnt = 0;
  int         ack_delay = 0;
  int         max_req_cnt = 0, trig_arm_cnt = 0, max_req_edge = 0, trig_arm_edge = 0;
  int         rise_cnt = 0;
  int         rise_at [256];
  int         e_edge = 0;
  logic       txen_prev = 1'b0;
  logic [7:0] chk_acc = 8'h00;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters and tx_en rise times, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.max_req === 1'b1) begin max_req_cnt++; max_req_edge = cyc; end
    if (ifc.trig_arm === 1'b1) begin trig_arm_cnt++; trig_arm_edge = cyc; end
    if (ifc.tx_en === 1'b1 && txen_prev !== 1'b1) begin rise_at[rise_cnt & 255] = cyc; rise_cnt++; end
    txen_prev = ifc.tx_en;
  end

  // UART transmitter model: accepts a byte, stays busy a few cycles.
  initial begin
    ifc.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ifc.tx_en === 1'b1 && ifc.tx_ready === 1'b1) begin
        got_q.push_back(ifc.tx_data);
        hs_cnt++;
        if (ack_delay > 0) begin repeat (ack_delay) @(posedge clk); #1; end
        ifc.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifc.tx_ready = 1'b1;
      end
    end
  end

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
    chk_acc = chk_acc ^ b;
  endtask

  task automatic close_exp();
`ifdef CMD_CHECKSUM_EN
    exp_q.push_back(chk_acc);
`endif
    chk_acc = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ifc.rx_data = b; ifc.rx_data_ready = 1'b1;
    e_edge = cyc + 1;
    @(negedge clk);
    ifc.rx_data_ready = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (got_q.size() >= n && ifc.busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_count(input int which, input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (((which == 0) ? max_req_cnt : trig_arm_cnt) > base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_max(input logic [15:0] v);
    ifc.max_value = v; ifc.max_valid = 1'b1;
    @(negedge clk);
    ifc.max_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++; if (ifc.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", ifc.tx_data); end
    tests_run++; if (ifc.tx_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_en: got %b want 0", ifc.tx_en); end
    tests_run++; if (ifc.max_req !== 1'b0 || ifc.trig_arm !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got %b%b want 00", ifc.max_req, ifc.trig_arm); end
    tests_run++; if (ifc.max_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_max_ch: got %0d want 0", ifc.max_ch); end
    tests_run++; if (ifc.busy !== 1'b0 || ifc.overrun_cnt !== 8'h00) begin tests_failed++; $display("FAIL reset_busy_ovr: got %b/%h want 0/00", ifc.busy, ifc.overrun_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ping(input string nm);
    int hs0, n; bit ok; logic [7:0] e, g;
    hs0 = hs_cnt;
    push_exp(8'hAA); close_exp();
    n = exp_q.size();
    send_byte(8'h00);
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL %s_done: got %0d bytes want %0d", nm, got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL %s_byte: got %h want %h", nm, g, e); end
    end
    tests_run++; if (hs_cnt - hs0 !== n) begin tests_failed++; $display("FAIL %s_handshakes: got %0d want %0d", nm, hs_cnt - hs0, n); end
    tests_run++; if (ifc.busy !== 1'b0) begin tests_failed++; $display("FAIL %s_busy: got %b want 0", nm, ifc.busy); end
  endtask

  task automatic test_max(input logic [7:0] op, input logic [15:0] v, input logic [1:0] ch);
    int base, n; bit ok; logic [7:0] e, g;
    base = max_req_cnt;
    push_exp(op); push_exp(v[15:8]); push_exp(v[7:0]); close_exp();
    n = exp_q.size();
    send_byte(op);
    tests_run++; if (ifc.busy !== 1'b1) begin tests_failed++; $display("FAIL max_busy_rise: got %b want 1", ifc.busy); end
    wait_count(0, base, ok);
    tests_run++; if (!ok || max_req_edge !== e_edge + 2) begin tests_failed++; $display("FAIL max_req_latency: got edge %0d want %0d", max_req_edge, e_edge + 2); end
    tests_run++; if (ifc.max_ch !== ch) begin tests_failed++; $display("FAIL max_ch: got %0d want %0d", ifc.max_ch, ch); end
    pulse_max(v);
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL max_done: got %0d bytes want %0d", got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL max_byte: got %h want %h", g, e); end
    end
    tests_run++; if (max_req_cnt - base !== 1) begin tests_failed++; $display("FAIL max_req_count: got %0d want 1", max_req_cnt - base); end
  endtask

  task automatic test_unknown_overrun();
    int base, hs0, n; bit ok; logic [7:0] e, g;
    base = max_req_cnt; hs0 = hs_cnt;
    push_exp(8'hEE); push_exp(8'h7F); close_exp();
    n = exp_q.size();
    send_byte(8'h7F);
    for (int i = 0; i < 100 && hs_cnt == hs0; i++) @(negedge clk);
    send_byte(8'h41);
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL unk_done: got %0d bytes want %0d", got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL unk_byte: got %h want %h", g, e); end
    end
    tests_run++; if (ifc.overrun_cnt !== 8'd1) begin tests_failed++; $display("FAIL unk_overrun: got %0d want 1", ifc.overrun_cnt); end
    tests_run++; if (max_req_cnt !== base) begin tests_failed++; $display("FAIL unk_no_req: got %0d pulses want 0", max_req_cnt - base); end
  endtask

  task automatic test_trigger(input bit hit);
    int base, rb, n; bit ok; logic [7:0] e, g;
    base = trig_arm_cnt; rb = rise_cnt;
    push_exp(hit ? 8'hD1 : 8'hDE); close_exp();
    n = exp_q.size();
    send_byte(8'hD0);
    wait_count(1, base, ok);
    tests_run++; if (!ok || trig_arm_edge !== e_edge + 2) begin tests_failed++; $display("FAIL trig_arm_latency: got edge %0d want %0d", trig_arm_edge, e_edge + 2); end
    if (hit) begin
      repeat (500) @(negedge clk);
      ifc.trig_hit = 1'b1; @(negedge clk); ifc.trig_hit = 1'b0;
    end
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL trig_done: got %0d bytes want %0d", got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL trig_byte: got %h want %h", g, e); end
    end
    if (!hit) begin
      tests_run++;
      if (rise_at[rb & 255] - trig_arm_edge !== 1000) begin tests_failed++; $display("FAIL trig_timeout_cycles: got %0d want 1000", rise_at[rb & 255] - trig_arm_edge); end
    end
    tests_run++; if (trig_arm_cnt - base !== 1) begin tests_failed++; $display("FAIL trig_arm_count: got %0d want 1", trig_arm_cnt - base); end
  endtask

  task automatic test_max_timeout(input bit late_valid);
    int base, n; bit ok; logic [7:0] e, g;
    base = max_req_cnt;
    if (late_valid) begin push_exp(8'h41); push_exp(8'hBE); push_exp(8'hEF); end
    else begin push_exp(8'hEE); push_exp(8'h41); end
    close_exp();
    n = exp_q.size();
    send_byte(8'h41);
    wait_count(0, base, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmo_req: got %0d pulses want 1", max_req_cnt - base); end
    if (late_valid) begin
      for (int i = 0; i < 1100 && cyc < max_req_edge + 998; i++) @(negedge clk);
      pulse_max(16'hBEEF);
    end
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL tmo_done: got %0d bytes want %0d", got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL tmo_byte(late=%0d): got %h want %h", late_valid, g, e); end
    end
  endtask

  task automatic test_stray();
    int hs0, mb, tb0;
    hs0 = hs_cnt; mb = max_req_cnt; tb0 = trig_arm_cnt;
    @(negedge clk);
    ifc.trig_hit = 1'b1; ifc.max_valid = 1'b1;
    @(negedge clk);
    ifc.trig_hit = 1'b0; ifc.max_valid = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++; if (hs_cnt !== hs0 || got_q.size() !== 0) begin tests_failed++; $display("FAIL stray_tx: got %0d bytes want 0", hs_cnt - hs0); end
    tests_run++; if (ifc.busy !== 1'b0 || max_req_cnt !== mb || trig_arm_cnt !== tb0) begin tests_failed++; $display("FAIL stray_activity: got busy %b want 0", ifc.busy); end
  endtask

  task automatic test_overrun_sat();
    int n; bit ok; logic [7:0] e, g;
    push_exp(8'hDE); close_exp();
    n = exp_q.size();
    send_byte(8'hD0);
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    tests_run++; if (ifc.overrun_cnt !== 8'hFF) begin tests_failed++; $display("FAIL overrun_sat: got %h want ff", ifc.overrun_cnt); end
    wait_bytes(n, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL sat_done: got %0d bytes want %0d", got_q.size(), n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL sat_byte: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    int base, hs0; bit ok; logic [7:0] e, g;
    base = max_req_cnt; hs0 = hs_cnt;
    ack_delay = 6;
    exp_q.push_back(8'h41); exp_q.push_back(8'h56);
    send_byte(8'h41);
    wait_count(0, base, ok);
    pulse_max(16'h5678);
    for (int i = 0; i < 200 && hs_cnt < hs0 + 2; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (ifc.tx_en !== 1'b0) begin tests_failed++; $display("FAIL rstmid_tx_en: got %b want 0", ifc.tx_en); end
    tests_run++; if (ifc.busy !== 1'b0 || ifc.overrun_cnt !== 8'h00) begin tests_failed++; $display("FAIL rstmid_busy_ovr: got %b/%h want 0/00", ifc.busy, ifc.overrun_cnt); end
    rst = 1'b0;
    ack_delay = 0;
    repeat (40) @(negedge clk);
    tests_run++; if (hs_cnt - hs0 !== 2) begin tests_failed++; $display("FAIL rstmid_bytes: got %0d want 2", hs_cnt - hs0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      tests_run++; if (g !== e) begin tests_failed++; $display("FAIL rstmid_byte: got %h want %h", g, e); end
    end
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    ifc.rx_data = 8'h00; ifc.rx_data_ready = 1'b0;
    ifc.max_valid = 1'b0; ifc.max_value = 16'h0000; ifc.trig_hit = 1'b0;
    test_reset();
    test_ping("ping");
    test_max(8'h41, 16'h1234, 2'd0);
    test_max(8'h42, 16'h8001, 2'd1);
    test_unknown_overrun();
    test_trigger(1'b1);
    test_trigger(1'b0);
    test_max_timeout(1'b0);
    test_max_timeout(1'b1);
    test_stray();
    test_overrun_sat();
    test_reset_mid();
    test_ping("ping_after_reset");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command sequencer between the host UART and the acoustics datapath. It accepts one command byte at a time from the UART receiver and decodes it. It starts the requested datapath operation (per-channel max report or trigger-detect arm), waits for completion or timeout, then streams a short response back through the UART transmitter handshake. It is the single owner of the UART TX path and of the datapath request strobes in PRIMARY.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd100_000_000 — clk cycles allowed for a datapath reply before a timeout response; 1 s at 100 MHz.
- TIMEOUT_W, 32 — width of the timeout counter.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset. Top level drives it from ~reset_b.
- rx_data  in  8  received byte from the UART receiver (RX_Data_out).
- rx_data_ready  in  1  one-cycle pulse in the clk domain; rx_data is valid in that cycle.
- tx_data  out  8  byte to transmit (to TX_Data_in).
- tx_en  out  1  transmit request (to TX_en).
- tx_ready  in  1  transmitter idle (TX_Ready_To_Send).
- max_req  out  1  one-cycle pulse requesting the max-magnitude report.
- max_ch  out  2  channel for max_req: 0 = adc1, 1 = adc2. Held stable until max_valid or timeout.
- max_valid  in  1  one-cycle pulse; max_value is valid in that cycle.
- max_value  in  16  signed max sample from the datapath.
- trig_arm  out  1  one-cycle pulse arming trigger detection.
- trig_hit  in  1  one-cycle pulse when the trigger fires.
- busy  out  1  high in every state except IDLE.
- overrun_cnt  out  8  saturating count of bytes dropped while busy.

## Operation
- Opcodes:
  - 0x41 → max report for ch0.
  - 0x42 → max report for ch1.
  - 0xD0 → arm the trigger.
  - 0x00 → ping.
  - Any other byte → error.
- Responses, transmitted in order:
  - Max report: opcode, max_value[15:8], max_value[7:0].
  - Max timeout: 0xEE, opcode.
  - Trigger hit: 0xD1.
  - Trigger timeout: 0xDE.
  - Ping: 0xAA.
  - Unknown opcode: 0xEE, opcode.
- States: IDLE, DECODE, MAX_WAIT, TRIG_WAIT, TX_LOAD, TX_HOLD, TX_GAP.
  - IDLE: on rx_data_ready, latch rx_data into the opcode register and go to DECODE.
  - DECODE:
    - 0x41/0x42: pulse max_req, set max_ch, clear the timer, go to MAX_WAIT.
    - 0xD0: pulse trig_arm, clear the timer, go to TRIG_WAIT.
    - Otherwise: load the response buffer and go to TX_LOAD.
  - MAX_WAIT / TRIG_WAIT:
    - The timer increments every cycle.
    - On max_valid / trig_hit, load the success response.
    - When the timer reaches TIMEOUT_CYCLES-1, load the timeout response.
    - Either way, go to TX_LOAD.
    - A completion and the terminal timer count in the same cycle resolve as success.
  - TX_LOAD: when tx_ready=1, drive tx_data from buffer[idx], set tx_en=1, go to TX_HOLD.
  - TX_HOLD: hold tx_en and tx_data until tx_ready=0. Then drop tx_en, increment idx, go to TX_GAP.
  - TX_GAP: if idx equals the response length, go to IDLE; otherwise go to TX_LOAD.
- Response buffer: 4 × 8 bits, with a 3-bit length register and a 2-bit index; idx never wraps.
- Stray max_valid or trig_hit pulses outside the matching wait state are ignored.
- rx_data_ready while busy=1: the byte is dropped and overrun_cnt increments, saturating at 0xFF.
- Reset mid-operation:
  - All state returns to IDLE and any pending response is discarded.
  - tx_en drops in the same edge, so the UART may finish a byte already started.

## Timing
- Reset values: tx_data=0x00, tx_en=0, max_req=0, max_ch=0, trig_arm=0, busy=0, overrun_cnt=0.
- All outputs are registered.
- Request latency:
  - Edge E samples rx_data_ready.
  - DECODE occupies E+1.
  - max_req / trig_arm are high for exactly the cycle after edge E+2.
  - busy rises after edge E.
- Timeout: exactly TIMEOUT_CYCLES cycles in the wait state, counted from the first wait cycle.
- First tx_en rises one edge after TX_LOAD is entered with tx_ready=1.
- Minimum turnaround between two response bytes: 3 clk cycles plus the UART idle-to-ready time.
- busy falls on the edge that leaves TX_GAP. A byte arriving in that same cycle is dropped.

## Configuration
- CMD_CHECKSUM_EN:
  - Defined: every response carries one extra trailing byte, the XOR of all preceding response bytes. Lengths become 4/3/2/2/2/3 (max report / max timeout / trigger hit / trigger timeout / ping / unknown). Example: ping sends 0xAA, 0xAA.
  - Undefined: no checksum byte, and the buffer may be 3 entries.

## Test plan
- Ping: inject 0x00 → exactly one byte 0xAA on tx_data with one tx_en handshake; busy is low afterwards; with CMD_CHECKSUM_EN, 0xAA then 0xAA.
- Max ch0: inject 0x41 → max_req pulses once with max_ch=0; drive max_valid with max_value=0x1234 → bytes 0x41, 0x12, 0x34 in order.
- Trigger: inject 0xD0 → trig_arm pulses; trig_hit 500 cycles later → 0xD1. Repeat with no trig_hit and TIMEOUT_CYCLES=1000 → 0xDE exactly 1000 cycles after the first TRIG_WAIT cycle.
- Unknown opcode plus overrun: inject 0x7F, then 0x41 during transmit → response 0xEE, 0x7F; overrun_cnt=1; no max_req pulse.
- Simultaneous events: max_valid on the terminal timeout cycle → success response. Stray trig_hit in IDLE → no output activity.
- Reset during TX_HOLD of the second byte of a max response → tx_en=0 on the next edge, busy=0, no further bytes; a following 0x00 yields 0xAA.
